// File: rtl/ieeedrv_rom_arbiter_if.sv
// Bus bundle between the IEEE drive channels, the shared ROM and the ROM arbiter.
// master = drive/ROM side, slave = arbiter.
interface ieeedrv_rom_arbiter_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 14,
  parameter int unsigned DW  = 8
);
  logic              strobe;
  logic [NCH-1:0]    ch_en;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;
  logic [AW-1:0]     rom_addr;
  logic [2:0]        rom_chan;
  logic [DW-1:0]     rom_q;
  logic              cache_inv;
  logic              busy;
  logic              overrun;

  modport master (
    output strobe, ch_en, ch_addr, rom_q, cache_inv,
    input  ch_data, ch_valid, rom_addr, rom_chan, busy, overrun
  );

  modport slave (
    input  strobe, ch_en, ch_addr, rom_q, cache_inv,
    output ch_data, ch_valid, rom_addr, rom_chan, busy, overrun
  );
endinterface

// File: rtl/ieeedrv_rom_arbiter.sv
// Time-multiplexed read arbiter sharing one synchronous ROM among up to 8 drive channels.
// Optional per-channel last-address cache is enabled with `define IEEEDRV_ROM_CACHE_EN.
module ieeedrv_rom_arbiter #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned AW      = 14,
  parameter int unsigned DW      = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input logic                   clk_sys,
  input logic                   reset_n,
  ieeedrv_rom_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned IDX_W = 3;

  // NEXT is resolved on the capture edge itself, so the register only holds IDLE or ACCESS.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_NEXT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic              hit_q, hit_d;
  logic [NCH-1:0]    snap_en_q, snap_en_d;
  logic [AW-1:0]     snap_addr_q [NCH];
  logic [AW-1:0]     snap_addr_d [NCH];
  logic [NCH*DW-1:0] data_q, data_d;
  logic [NCH-1:0]    valid_q, valid_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]  rom_chan_q, rom_chan_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              start_c;
  logic              capture_c;
  logic              load_c;
  logic [IDX_W:0]    first_c;
  logic [IDX_W:0]    nxt_c;
  logic              sel_found_c;
  logic [IDX_W-1:0]  sel_idx_c;
  logic [AW-1:0]     sel_addr_c;
  logic              sel_hit_c;

  // Lowest enabled channel with index >= lo; MSB of the result flags "found".
  function automatic logic [IDX_W:0] pick(input logic [NCH-1:0] en, input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (en[i] && (i >= lo)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  // Channel selection: live inputs on a start, the snapshot while sequencing.
  always_comb begin : sel_proc
    first_c     = pick(bus.ch_en, 0);
    nxt_c       = pick(snap_en_q, int'(cur_q) + 1);
    start_c     = (state_q == ST_IDLE) && bus.strobe && first_c[IDX_W];
    capture_c   = (state_q == ST_ACCESS) && (cnt_q == '0);
    sel_found_c = nxt_c[IDX_W];
    sel_idx_c   = nxt_c[IDX_W-1:0];
    if (state_q == ST_IDLE) begin
      sel_found_c = first_c[IDX_W];
      sel_idx_c   = first_c[IDX_W-1:0];
    end
    sel_addr_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (sel_idx_c == IDX_W'(i)) begin
        sel_addr_c = (state_q == ST_IDLE) ? bus.ch_addr[i*AW +: AW] : snap_addr_q[i];
      end
    end
  end

`ifdef IEEEDRV_ROM_CACHE_EN
  logic [AW-1:0]  last_addr_q [NCH];
  logic [NCH-1:0] hit_ok_q;

  always_comb begin : hit_proc
    sel_hit_c = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (sel_idx_c == IDX_W'(i)) sel_hit_c = hit_ok_q[i] && (last_addr_q[i] == sel_addr_c);
    end
  end

  // Invalidate wins over a capture landing on the same edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin : cache_reg
    if (!reset_n) begin
      hit_ok_q <= '0;
      for (int i = 0; i < int'(NCH); i++) last_addr_q[i] <= '0;
    end else if (bus.cache_inv) begin
      hit_ok_q <= '0;
      for (int i = 0; i < int'(NCH); i++) last_addr_q[i] <= '0;
    end else if (capture_c && !hit_q) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (cur_q == IDX_W'(i)) begin
          last_addr_q[i] <= rom_addr_q;
          hit_ok_q[i]    <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_cache_inv;
  assign unused_cache_inv = bus.cache_inv;
  assign sel_hit_c        = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin : state_reg
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : next_state_proc
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_ACCESS;
      ST_ACCESS: if (capture_c && !sel_found_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin : output_proc
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    hit_d       = hit_q;
    snap_en_d   = snap_en_q;
    snap_addr_d = snap_addr_q;
    data_d      = data_q;
    valid_d     = '0;
    rom_addr_d  = rom_addr_q;
    rom_chan_d  = rom_chan_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q | (bus.strobe & busy_q);
    load_c      = 1'b0;

    if ((state_q == ST_IDLE) && bus.strobe) begin
      snap_en_d = bus.ch_en;
      for (int i = 0; i < int'(NCH); i++) snap_addr_d[i] = bus.ch_addr[i*AW +: AW];
      load_c = first_c[IDX_W];
    end

    if (state_q == ST_ACCESS) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (cur_q == IDX_W'(i)) begin
            valid_d[i] = 1'b1;
            if (!hit_q) data_d[i*DW +: DW] = bus.rom_q;
          end
        end
        if (sel_found_c) load_c = 1'b1;
        else             busy_d = 1'b0;
      end
    end

    // A cache hit skips the ROM and costs a single cycle.
    if (load_c) begin
      cur_d  = sel_idx_c;
      busy_d = 1'b1;
      if (sel_hit_c) begin
        cnt_d = '0;
        hit_d = 1'b1;
      end else begin
        cnt_d      = CNT_W'(ROM_LAT);
        hit_d      = 1'b0;
        rom_addr_d = sel_addr_c;
        rom_chan_d = sel_idx_c;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin : data_reg
    if (!reset_n) begin
      cnt_q      <= '0;
      cur_q      <= '0;
      hit_q      <= 1'b0;
      snap_en_q  <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      rom_addr_q <= '0;
      rom_chan_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) snap_addr_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      hit_q       <= hit_d;
      snap_en_q   <= snap_en_d;
      snap_addr_q <= snap_addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rom_addr_q  <= rom_addr_d;
      rom_chan_q  <= rom_chan_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.ch_data  = data_q;
  assign bus.ch_valid = valid_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_chan = rom_chan_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_ieeedrv_rom_arbiter.sv
// Self-checking bench for ieeedrv_rom_arbiter: directed and random sequences against a
// slot-schedule reference model; set IEEEDRV_ROM_CACHE_EN to match a cached build.
module tb_ieeedrv_rom_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 1;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ieeedrv_rom_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  ieeedrv_rom_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ROM_LAT(LAT)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  // Synchronous ROM with LAT cycles from address to data.
  logic [AW-1:0] rom_pipe [LAT];
  always @(posedge clk_sys) begin
    rom_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < int'(LAT); i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_q = rom_f(rom_pipe[LAT-1]);

  int vectors     = 0;
  int miscompares = 0;

  logic [NCH*DW-1:0] m_data;
  logic [AW-1:0]     m_rom_addr;
  logic [2:0]        m_rom_chan;
  logic              m_ovr;
`ifdef IEEEDRV_ROM_CACHE_EN
  logic [AW-1:0]     m_last [NCH];
  logic [NCH-1:0]    m_ok;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*AW-1:0] rand_addrs();
    return (NCH*AW)'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    m_data     = '0;
    m_rom_addr = '0;
    m_rom_chan = '0;
    m_ovr      = 1'b0;
`ifdef IEEEDRV_ROM_CACHE_EN
    m_ok = '0;
    for (int i = 0; i < int'(NCH); i++) m_last[i] = '0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  bus.ch_data,  '0);
    check({tag, "_valid"}, bus.ch_valid, '0);
    check({tag, "_raddr"}, bus.rom_addr, '0);
    check({tag, "_rchan"}, bus.rom_chan, '0);
    check({tag, "_busy"},  bus.busy,     '0);
    check({tag, "_ovr"},   bus.overrun,  '0);
  endtask

  task automatic pulse_inv();
    bus.cache_inv = 1'b1;
    @(posedge clk_sys); #1;
    bus.cache_inv = 1'b0;
`ifdef IEEEDRV_ROM_CACHE_EN
    m_ok = '0;
    for (int i = 0; i < int'(NCH); i++) m_last[i] = '0;
`endif
  endtask

  // Serve enabled channels in ascending order; each costs LAT+1 cycles (1 on a cache hit).
  // With ovr_last set, a second strobe is applied on the final capture edge.
  task automatic do_seq(input logic [NCH-1:0] en, input logic [NCH*AW-1:0] addrs, input bit ovr_last);
    logic [2:0]     exp_chan  [64];
    logic [AW-1:0]  exp_addr  [64];
    logic [NCH-1:0] exp_valid [64];
    logic [2:0]     cur_chan;
    logic [AW-1:0]  cur_addr;
    logic [AW-1:0]  a;
    bit             hit;
    int             total;
    int             cost;
    int             ovr_at;
    logic           ovr_base;

    total    = 0;
    cur_chan = m_rom_chan;
    cur_addr = m_rom_addr;
    for (int n = 0; n < 64; n++) exp_valid[n] = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (en[i]) begin
        a   = addrs[i*AW +: AW];
        hit = 1'b0;
`ifdef IEEEDRV_ROM_CACHE_EN
        hit = m_ok[i] && (m_last[i] == a);
        if (!hit) begin
          m_last[i] = a;
          m_ok[i]   = 1'b1;
        end
`endif
        cost = hit ? 1 : int'(LAT) + 1;
        if (!hit) begin
          cur_chan = 3'(i);
          cur_addr = a;
          m_data[i*DW +: DW] = rom_f(a);
        end
        for (int n = total; n < total + cost; n++) begin
          exp_chan[n] = cur_chan;
          exp_addr[n] = cur_addr;
        end
        total = total + cost;
        exp_valid[total][i] = 1'b1;
      end
    end
    for (int n = total; n < 64; n++) begin
      exp_chan[n] = cur_chan;
      exp_addr[n] = cur_addr;
    end
    m_rom_chan = cur_chan;
    m_rom_addr = cur_addr;
    ovr_at     = ovr_last ? total : -1;
    ovr_base   = m_ovr;

    bus.ch_en   = en;
    bus.ch_addr = addrs;
    bus.strobe  = 1'b1;
    @(posedge clk_sys); #1;
    bus.strobe  = 1'b0;
    bus.ch_en   = NCH'($urandom());
    bus.ch_addr = rand_addrs();

    for (int n = 0; n <= total + 2; n++) begin
      check("busy",     bus.busy,     n < total);
      check("ch_valid", bus.ch_valid, exp_valid[n]);
      check("rom_chan", bus.rom_chan, exp_chan[n]);
      check("rom_addr", bus.rom_addr, exp_addr[n]);
      check("overrun",  bus.overrun,  ovr_base || (ovr_at > 0 && n >= ovr_at));
      bus.strobe = (ovr_at > 0) && (n == ovr_at - 1);
      @(posedge clk_sys); #1;
    end
    bus.strobe = 1'b0;
    if (ovr_at > 0) m_ovr = 1'b1;
    check("ch_data", bus.ch_data, m_data);
  endtask

  logic [NCH*AW-1:0] addrs;
  logic [NCH*AW-1:0] fixed;

  initial begin
    bus.strobe    = 1'b0;
    bus.ch_en     = '0;
    bus.ch_addr   = '0;
    bus.cache_inv = 1'b0;
    model_reset();

    repeat (2) @(posedge clk_sys);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // Four channels, known addresses and data
    addrs = {14'h0400, 14'h0300, 14'h0200, 14'h0100};
    do_seq(4'b1111, addrs, 1'b0);
    check("t1_data", bus.ch_data, 32'h0403_0201);

    // Sparse enable, then no channel enabled
    do_seq(4'b1010, rand_addrs(), 1'b0);
    do_seq(4'b0000, rand_addrs(), 1'b0);

    // Random enables and addresses, with repeats and idle gaps
    addrs = rand_addrs();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 0) addrs = rand_addrs();
      if ($urandom_range(0, 3) == 0) pulse_inv();
      repeat ($urandom_range(0, 3)) @(posedge clk_sys);
      #0;
      do_seq(NCH'($urandom_range(0, 15)), addrs, 1'b0);
    end

    // Repeated identical addresses, then an invalidate
    fixed = rand_addrs();
    do_seq(4'b1111, fixed, 1'b0);
    do_seq(4'b1111, fixed, 1'b0);
    pulse_inv();
    do_seq(4'b1111, fixed, 1'b0);

    // Strobe on the last capture edge: sticky overrun, no new sequence
    do_seq(4'b1111, rand_addrs(), 1'b1);
    repeat (5) @(posedge clk_sys);
    #1;
    check("ovr_sticky", bus.overrun, 1'b1);
    do_seq(4'b0110, rand_addrs(), 1'b0);

    // Reset in the middle of a full sequence
    bus.ch_en   = '1;
    bus.ch_addr = rand_addrs();
    bus.strobe  = 1'b1;
    @(posedge clk_sys); #1;
    bus.strobe  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      check("post_reset_valid", bus.ch_valid, '0);
      check("post_reset_busy",  bus.busy,     1'b0);
      @(posedge clk_sys); #1;
    end
    do_seq(4'b1111, rand_addrs(), 1'b0);
    do_seq(NCH'($urandom_range(1, 15)), rand_addrs(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ieeedrv_rom_arbiter.md
Name: ieeedrv_rom_arbiter

Overview:
- Time-multiplexed read arbiter that shares one synchronous DOS or controller ROM among up to 8 IEEE drive channels.
- Successor to the fixed-slot ROM mux, adding:
  - parametrised channel count, address width, data width and ROM read latency;
  - per-channel enable mask;
  - per-channel valid pulses, a busy flag and overrun detection.
- Sits between the drive instances and the ROM pair in the ieee_drive top level.
- Top level uses rom_chan to pick the ROM image (4040 or 8250) for the channel currently being served.

Parameters:
- NCH, 4: number of channels (1..8).
- AW, 14: ROM address width.
- DW, 8: ROM data width.
- ROM_LAT, 1: ROM read latency in cycles, address change to valid q (1..3).

Ports:
- clk_sys  in  1  system clock; everything is clocked on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- strobe  in  1  sequence start; a phase strobe such as ph2_r or ph2_f; one cycle wide.
- ch_en  in  NCH  per-channel enable.
- ch_addr  in  NCH*AW  channel addresses, packed; channel i occupies [i*AW +: AW].
- ch_data  out  NCH*DW  per-channel held ROM data, packed the same way.
- ch_valid  out  NCH  one-cycle pulse when ch_data[i] is updated.
- rom_addr  out  AW  registered address to the ROM.
- rom_chan  out  3  registered index of the channel currently being served.
- rom_q  in  DW  ROM data.
- cache_inv  in  1  cache invalidate; used only with the optional feature.
- busy  out  1  sequence in progress.
- overrun  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (reset_n low, asynchronous):
  - ch_data=0, ch_valid=0, rom_addr=0, rom_chan=0, busy=0, overrun=0, state=IDLE.
  - Asserting reset mid-sequence aborts it immediately; no further captures or pulses occur.
- States are IDLE, ACCESS and NEXT.
- IDLE, strobe=1:
  - Snapshot ch_addr and ch_en into internal registers.
  - Find the lowest-index enabled channel k.
  - If there is none, remain in IDLE with busy=0 and no ROM access.
  - Otherwise, on the same edge: rom_addr<=snap_addr[k], rom_chan<=k, busy<=1, wait counter<=ROM_LAT, go to ACCESS.
- ACCESS:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0:
    - ch_data[rom_chan]<=rom_q;
    - ch_valid[rom_chan]<=1 for exactly one cycle;
    - go to NEXT.
  - Capture therefore happens ROM_LAT+1 edges after the rom_addr edge.
- NEXT is combinational with the capture edge; it adds no extra cycle:
  - Select the next enabled snapshot channel with index greater than rom_chan.
  - If one exists, load rom_addr and rom_chan on the capture edge and restart ACCESS.
  - If none exists, busy<=0 on the capture edge and return to IDLE.
- Sequence length: for E enabled channels, busy stays high for exactly E*(ROM_LAT+1) cycles.
- Channels disabled in the snapshot: ch_data is held, ch_valid is never pulsed.
- Changes to ch_addr or ch_en while busy=1 do not affect the current sequence.
- strobe while busy=1, including the edge on which busy falls:
  - the strobe is ignored;
  - overrun<=1.
- At most one ch_valid bit is high in any cycle.
- rom_addr and rom_chan hold their last values while IDLE.
- Required timing margin: NCH*(ROM_LAT+1) must be less than the strobe period. With 16 MHz ce and 1 MHz phase at 32 MHz clk_sys there are 32 cycles per strobe.

Optional Feature:
- Macro: IEEEDRV_ROM_CACHE_EN.
- Defined:
  - Each channel keeps last_addr[i] and a hit-ok flag, both cleared by reset or by cache_inv=1.
  - cache_inv has priority over a same-cycle capture.
  - If an enabled channel's snapshot address equals last_addr[i] and hit-ok is set, there is no ROM access: ch_valid[i] pulses and the sequence advances one edge after selection. The access costs 1 cycle instead of ROM_LAT+1.
  - rom_addr and rom_chan are not updated for a hit.
  - On a miss capture: last_addr[i]<=address, hit-ok<=1.
- Undefined: cache_inv is ignored and every enabled channel always performs the full ROM access.

Test Plan:
1. NCH=4, ROM_LAT=1, ch_en=4'b1111, addresses 0x0100/0x0200/0x0300/0x0400, ROM q=addr[7:0]^addr[13:8] -> ch_valid pulses at edges T0+2/4/6/8; ch_data = 0x01/0x02/0x03/0x04; busy high for 8 cycles.
2. ch_en=4'b1010, ROM_LAT=2 -> only channels 1 and 3 are served; busy lasts 6 cycles; ch_data[0] and ch_data[2] unchanged; rom_chan sequence is 1 then 3.
3. ch_en=0 with strobe -> busy stays 0, no ch_valid, rom_addr unchanged.
4. Second strobe on the last capture edge of a sequence -> overrun=1 and stays 1; no new sequence starts; overrun is cleared only by pulsing reset_n low.
5. reset_n low in the middle of a 4-channel sequence after 3 cycles -> all outputs are 0 immediately; no ch_valid after release; the next strobe runs a full sequence.
6. With IEEEDRV_ROM_CACHE_EN and repeated identical addresses on 4 channels -> second sequence busy lasts 4 cycles with unchanged data; after cache_inv, the next sequence lasts 4*(ROM_LAT+1) cycles.
